ser_8b10b_tx: RTL
=================

Name: ser_8b10b_tx

Overview:
- Single-clock successor to the current 8b/10b serializer. Accepts words of BYTES_PER_WORD bytes over a valid/ready handshake.
- Encodes each byte as a data (D) or control (K) 8b/10b symbol. Running disparity (RD) is tracked per sub-block and carried across symbols and words.
- Shifts the encoded symbols out one bit per clock. When no data is pending, it optionally fills the line with K28.5 commas.
- Sits between the framing logic and the lane pad.

Parameters:
- BYTES_PER_WORD, 1, number of bytes per accepted word (legal range 1..4).
- IDLE_COMMA, 1, 1 = transmit K28.5 when idle; 0 = line held at 0 when idle.

Ports:
- i_Clk  in  1  bit clock; all state is on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Valid  in  1  input word valid.
- i_Data  in  8*BYTES_PER_WORD  bytes to send. Byte 0 = i_Data[7:0] and is transmitted first.
- i_K  in  BYTES_PER_WORD  per-byte control flag (1 = K symbol).
- o_Ready  out  1  word is accepted on any edge where i_Valid && o_Ready.
- o_Ser_Data  out  1  serial line.
- o_10B  out  10*BYTES_PER_WORD  last loaded symbol group, symbol 0 in [9:0], bit a at the LSB.
- o_RD  out  1  current running disparity after the last loaded symbol (0 = RD-, 1 = RD+).
- o_Code_Err  out  1  one-cycle pulse: an illegal K code was accepted.
- o_Busy  out  1  shifter holds untransmitted bits.

Behaviour:
- Reset (async, i_Rst_n=0): shifter=0, bit count=0, RD=RD-, o_Ser_Data=0, o_10B=0, o_RD=0, o_Code_Err=0, o_Busy=0. An in-flight word is dropped.
- State: shift register of 10*BYTES_PER_WORD bits; counter cnt of width $clog2(10*BYTES_PER_WORD+1).
- o_Ready = (cnt <= 1). It is combinational from state only and never depends on i_Valid.
- Each edge when cnt <= 1:
  - If i_Valid: load the encoded word and set cnt = 10*BYTES_PER_WORD.
  - Else if IDLE_COMMA: load one K28.5 for the current RD and set cnt = 10.
  - Else: cnt = 0.
- Each edge when cnt > 1: shift right by one bit, cnt = cnt - 1.
- Result: back-to-back words stream with no gap. The first bit of an accepted word appears on o_Ser_Data in the cycle after the accept edge.
- o_Ser_Data = shifter[0] when cnt != 0, else 0. o_Busy = (cnt != 0).
- Symbol bit order in the shifter: a,b,c,d,e,i,f,g,h,j from LSB upward; bit a is transmitted first.
- Encoding, per symbol:
  - 5b/6b is selected by the incoming RD.
  - 3b/4b is selected by the RD after the 6b sub-block.
  - RD flips only after a non-neutral sub-block (neutral means equal count of 1s and 0s).
  - The D.x.A7 alternate (0111 at RD-, 1000 at RD+) is used when RD- with e=i=1, or RD+ with e=i=0. This applies to x = 17, 18, 20 at RD- and x = 11, 13, 14 at RD+.
- Multi-byte words: symbols are encoded in a chain. Symbol n uses the RD out of symbol n-1; the last RD is registered into o_RD at load. Idle commas update RD the same way.
- Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. Any other byte with i_K=1 is encoded as K28.5 at the current RD, and o_Code_Err pulses on the cycle after the load. The rest of the word is unaffected.
- o_10B and o_RD update only on load edges, including comma loads.
- Deassertion of i_Rst_n mid-word: transmission restarts with the next load. If IDLE_COMMA=1, the first edge after reset release loads a comma with RD-.

Decomposition:
- Package ser_8b10b_pkg holds:
  - the constants K28_5_RDN = 10'b0101111100 and K28_5_RDP = 10'b1010000011 (LSB-first storage, i.e. abcdei=001111 fghj=1010 and its complement);
  - 5b/6b and 3b/4b table functions;
  - a legal-K check function.
- Sub-module enc_8b10b_sym: combinational single-symbol encoder with inputs data[7:0], k, rd_in and outputs sym[9:0], rd_out, k_err. The top instantiates BYTES_PER_WORD copies in an RD chain.
- The top holds the shifter, counter, handshake and registers.

Test Plan:
- Reset release, i_Valid=0, IDLE_COMMA=1 -> line carries 0011111010 then 1100000101 (a first), alternating; o_RD toggles 1,0,1…; o_Ready=1 on every 10th cycle.
- RD-, send D.0.0 (i_Data=0x00, i_K=0) -> 100111 0100 transmitted; o_RD=0 afterwards.
- Send D.21.5 (0xB5) at RD- and at RD+ -> 101010 1010 both times; o_RD unchanged.
- RD-, send D.17.7 (0xF1) -> 100011 0111 (A7 alternate); o_RD=1.
- BYTES_PER_WORD=2, i_Valid held high with a new word each ready -> continuous 20-bit groups with no idle bits; RD chain correct across the byte and word boundary.
- i_K=1 with 0x00 -> K28.5 emitted and o_Code_Err=1 for exactly one cycle. Separately: assert i_Rst_n=0 mid-word -> o_Ser_Data=0 immediately, o_RD=0, partial word never completes.

Source files
------------

// File: rtl/ser_8b10b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_8b10b_pkg : 8b/10b code tables, comma constants, legal-K check    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ser_8b10b_pkg;

  // Symbols are stored LSB-first: bit 0 = a, bit 9 = j.
  localparam logic [9:0] K28_5_RDN  = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP  = 10'b1010000011;
  localparam logic [7:0] K28_5_BYTE = 8'hBC;

  // Returns abcdei with a in bit 5.
  function automatic logic [5:0] enc_5b6b(input logic [4:0] x, input logic k, input logic rd);
    logic [5:0] c;
    c = 6'b000000;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  5'd31: c = 6'b101011;
      default: c = 6'b000000;
    endcase
    if (k && (x == 5'd28)) c = 6'b001111;
    // D.7 is neutral but still has a distinct RD+ form.
    if (rd && (($countones(c) != 3) || (x == 5'd7))) c = ~c;
    return c;
  endfunction

  // Returns fghj with f in bit 3; table holds the RD- column.
  function automatic logic [3:0] enc_3b4b(input logic [2:0] y, input logic k, input logic rd,
                                          input logic alt);
    logic [3:0] c;
    c = 4'b0000;
    if (k) begin
      case (y)
        3'd0: c = 4'b1011;  3'd1: c = 4'b0110;  3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;  3'd5: c = 4'b0101;  3'd6: c = 4'b1001;  3'd7: c = 4'b0111;
        default: c = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;
        3'd7: c = alt ? 4'b0111 : 4'b1110;
        default: c = 4'b0000;
      endcase
    end
    if (rd && !(!k && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))) c = ~c;
    return c;
  endfunction

  function automatic logic k_legal(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_8b10b_sym.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_8b10b_sym : combinational single-symbol 8b/10b encoder            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module enc_8b10b_sym
  import ser_8b10b_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic       i_k,
  input  logic       i_rd_in,
  output logic [9:0] o_sym,
  output logic       o_rd_out,
  output logic       o_k_err
);

  logic [7:0] w_byte;
  logic [5:0] w_c6;
  logic [3:0] w_c4;
  logic       w_rd_mid;
  logic       w_alt;

  assign o_k_err  = i_k && !k_legal(i_data);
  assign w_byte   = o_k_err ? K28_5_BYTE : i_data;
  assign w_c6     = enc_5b6b(w_byte[4:0], i_k, i_rd_in);
  assign w_rd_mid = i_rd_in ^ ($countones(w_c6) != 3);
  // A7 avoids a run of five equal bits across the e,i / f,g,h boundary.
  assign w_alt    = !i_k && (w_byte[7:5] == 3'd7) &&
                    (w_rd_mid ? (w_c6[1:0] == 2'b00) : (w_c6[1:0] == 2'b11));
  assign w_c4     = enc_3b4b(w_byte[7:5], i_k, w_rd_mid, w_alt);
  assign o_rd_out = w_rd_mid ^ ($countones(w_c4) != 2);
  assign o_sym    = {w_c4[0], w_c4[1], w_c4[2], w_c4[3],
                     w_c6[0], w_c6[1], w_c6[2], w_c6[3], w_c6[4], w_c6[5]};

endmodule
`default_nettype wire

// File: rtl/ser_8b10b_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_8b10b_tx : word-wide 8b/10b encoder and 1-bit serializer          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ser_8b10b_tx
  import ser_8b10b_pkg::*;
#(
  parameter int BYTES_PER_WORD = 1,
  parameter bit IDLE_COMMA     = 1'b1
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic                        i_Valid,
  input  logic [8*BYTES_PER_WORD-1:0] i_Data,
  input  logic [BYTES_PER_WORD-1:0]   i_K,
  output logic                        o_Ready,
  output logic                        o_Ser_Data,
  output logic [10*BYTES_PER_WORD-1:0] o_10B,
  output logic                        o_RD,
  output logic                        o_Code_Err,
  output logic                        o_Busy
);

  localparam int W  = 10 * BYTES_PER_WORD;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] c_WORD_CNT  = CW'(W);
  localparam logic [CW-1:0] c_COMMA_CNT = CW'(10);
  localparam logic [CW-1:0] c_ONE       = CW'(1);

  logic [W-1:0]              r_shift;
  logic [W-1:0]              r_10b;
  logic [CW-1:0]             r_cnt;
  logic                      r_rd;
  logic                      r_code_err;

  logic [W-1:0]              w_word;
  logic [BYTES_PER_WORD:0]   w_rd_chain;
  logic [BYTES_PER_WORD-1:0] w_k_err;
  logic [9:0]                w_comma;
  logic                      w_ready;

  assign w_rd_chain[0] = r_rd;

  // Each symbol's encoder starts from the RD left by the previous symbol.
  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_sym
    enc_8b10b_sym u_enc (
      .i_data   (i_Data[8*g +: 8]),
      .i_k      (i_K[g]),
      .i_rd_in  (w_rd_chain[g]),
      .o_sym    (w_word[10*g +: 10]),
      .o_rd_out (w_rd_chain[g+1]),
      .o_k_err  (w_k_err[g])
    );
  end

  assign w_ready = (r_cnt <= c_ONE);
  assign w_comma = r_rd ? K28_5_RDP : K28_5_RDN;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_shift    <= '0;
      r_10b      <= '0;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_code_err <= 1'b0;
    end else begin
      r_code_err <= 1'b0;
      if (w_ready) begin
        if (i_Valid) begin
          r_shift    <= w_word;
          r_10b      <= w_word;
          r_cnt      <= c_WORD_CNT;
          r_rd       <= w_rd_chain[BYTES_PER_WORD];
          r_code_err <= |w_k_err;
        end else if (IDLE_COMMA) begin
          // K28.5 is disparity-unbalanced, so every comma flips RD.
          r_shift <= W'(w_comma);
          r_10b   <= W'(w_comma);
          r_cnt   <= c_COMMA_CNT;
          r_rd    <= ~r_rd;
        end else begin
          r_cnt <= '0;
        end
      end else begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt - c_ONE;
      end
    end
  end

  assign o_Ready    = w_ready;
  assign o_Busy     = (r_cnt != '0);
  assign o_Ser_Data = (r_cnt != '0) && r_shift[0];
  assign o_10B      = r_10b;
  assign o_RD       = r_rd;
  assign o_Code_Err = r_code_err;

endmodule
`default_nettype wire
